// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: FSM state codes, opcodes,
// aluop encodings and the control word produced by the output decoder.
package mips_ctrl_pkg;

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ADDIEXEC = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control word decode. Only the fetch enables look at mem_ready;
// everything else is a pure function of the state.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_word_t cw;

  always_comb begin
    cw = '0;
    case (state_i)
      S_FETCH: begin
        cw.memread = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
        cw.pcsrc   = PCSRC_ALU;
        cw.irwrite = mem_ready_i;
        cw.pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        cw.iord    = 1'b1;
        cw.memread = 1'b1;
      end
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      // Branch compares A-B; the target was parked in ALUOut during decode.
      S_BRANCH: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      S_JUMP: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  assign ctrl_o = cw;

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state logic,
// PC enable and retired-instruction counter. Output decode lives in mips_ctrl_outdec.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CTRL_W-1:0] ctrl_vec;
  ctrl_word_t        ctrl;
  logic              retire;

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_vec)
  );

  assign ctrl = ctrl_vec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR is stable here, so the lw/sw split is resolved a cycle after decode.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on its final transition back to fetch; illegal opcodes never do.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWRITE:                                   retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign pc_en    = ctrl.pcwrite | (ctrl.branch & zero);
  assign iord     = ctrl.iord;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign illegal  = (state_q == S_DECODE) && !is_legal_op(opcode);
  assign retired  = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM: each step pushes the expected control
// word and retired count to a scoreboard, which is popped and checked mid-cycle.
module tb_mips_multicycle_control;

  localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMREAD = 4,
                 T_MEMWB = 5, T_MEMWRITE = 6, T_EXEC = 7, T_ALUWB = 8, T_BRANCH = 9,
                 T_ADDIEXEC = 10, T_ADDIWB = 11, T_JUMP = 12;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011,
                         OPC_BEQ = 6'b000100, OPC_ADDI = 6'b001000, OPC_J = 6'b000010,
                         OPC_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic        illegal;
  logic [31:0] retired;

  logic [15:0] expQ[$];
  logic [31:0] retQ[$];
  int          errors = 0;
  int          checks = 0;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .iord      (iord),
    .memread   (memread),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Expected control word, packed {pc_en,iord,memread,memwrite,irwrite,regdst,memtoreg,
  // regwrite,alusrca,alusrcb,aluop,pcsrc,illegal}, taken from the state table.
  function automatic logic [15:0] expWord(input int st, input logic mr, input logic z,
                                          input logic ill);
    logic pe, io, mrd, mwr, irw, rd, m2r, rw, sa, il;
    logic [1:0] sb, ao, ps;
    {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      T_FETCH:    begin mrd = 1'b1; sb = 2'b01; irw = mr; pe = mr; end
      T_DECODE:   begin sb = 2'b11; il = ill; end
      T_MEMADR:   begin sa = 1'b1; sb = 2'b10; end
      T_MEMREAD:  begin io = 1'b1; mrd = 1'b1; end
      T_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
      T_MEMWRITE: begin io = 1'b1; mwr = 1'b1; end
      T_EXEC:     begin sa = 1'b1; ao = 2'b10; end
      T_ALUWB:    begin rw = 1'b1; rd = 1'b1; end
      T_BRANCH:   begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; end
      T_ADDIEXEC: begin sa = 1'b1; sb = 2'b10; end
      T_ADDIWB:   begin rw = 1'b1; end
      T_JUMP:     begin ps = 2'b10; pe = 1'b1; end
      default:    ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ps, il};
  endfunction

  task automatic checkOutput(input string tag);
    logic [15:0] exp, obs;
    logic [31:0] expRet;
    exp    = expQ.pop_front();
    expRet = retQ.pop_front();
    obs = {pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s ctrl: observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (retired === expRet) else begin
      errors++;
      $error("[TB] FAIL %s retired: observed=%0d expected=%0d", tag, retired, expRet);
    end
    checks++;
    assert ((memread & memwrite) === 1'b0) else begin
      errors++;
      $error("[TB] FAIL %s rdwr_excl: observed=%b expected=0", tag, memread & memwrite);
    end
  endtask

  // Drive inputs for the current cycle, check mid-cycle, then advance one clock.
  task automatic applyStimulus(input string tag, input int st, input logic [5:0] op,
                               input logic mr, input logic z, input logic ill,
                               input logic [31:0] ret);
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    expQ.push_back(expWord(st, mr, z, ill));
    retQ.push_back(ret);
    #1;
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OPC_R; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("reset", T_RST, OPC_R, 1'b1, 1'b0, 1'b0, 0);

    // R-type with stray mem_ready/zero in non-memory states
    applyStimulus("r_fetch",  T_FETCH,  OPC_R, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus("r_decode", T_DECODE, OPC_R, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus("r_exec",   T_EXEC,   OPC_R, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus("r_aluwb",  T_ALUWB,  OPC_R, 1'b0, 1'b0, 1'b0, 0);

    // lw abandoned by reset mid-MEMREAD
    applyStimulus("lwa_fetch",  T_FETCH,   OPC_LW, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("lwa_decode", T_DECODE,  OPC_LW, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus("lwa_memadr", T_MEMADR,  OPC_LW, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus("lwa_rd0",    T_MEMREAD, OPC_LW, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus("lwa_rd1",    T_MEMREAD, OPC_LW, 1'b0, 1'b0, 1'b0, 1);
    rst_n = 1'b0;
    expQ.push_back(expWord(T_RST, 1'b0, 1'b0, 1'b0));
    retQ.push_back(0);
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("reset_rel", T_RST, OPC_LW, 1'b1, 1'b0, 1'b0, 0);

    // lw with three wait cycles in MEMREAD
    applyStimulus("lw_fetch",  T_FETCH,   OPC_LW, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus("lw_decode", T_DECODE,  OPC_LW, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus("lw_memadr", T_MEMADR,  OPC_LW, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_wait", T_MEMREAD, OPC_LW, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus("lw_rddone", T_MEMREAD, OPC_LW, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus("lw_memwb",  T_MEMWB,   OPC_LW, 1'b0, 1'b0, 1'b0, 0);

    // beq taken, then not taken
    applyStimulus("beq1_fetch",  T_FETCH,  OPC_BEQ, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus("beq1_decode", T_DECODE, OPC_BEQ, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus("beq1_branch", T_BRANCH, OPC_BEQ, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus("beq0_fetch",  T_FETCH,  OPC_BEQ, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus("beq0_decode", T_DECODE, OPC_BEQ, 1'b0, 1'b1, 1'b0, 2);
    applyStimulus("beq0_branch", T_BRANCH, OPC_BEQ, 1'b1, 1'b0, 1'b0, 2);

    // unsupported opcode
    applyStimulus("ill_fetch",  T_FETCH,  OPC_BAD, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("ill_decode", T_DECODE, OPC_BAD, 1'b0, 1'b0, 1'b1, 3);

    // sw (with a fetch stall), j, addi back to back
    applyStimulus("sw_fstall", T_FETCH,    OPC_SW, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus("sw_fetch",  T_FETCH,    OPC_SW, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("sw_decode", T_DECODE,   OPC_SW, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus("sw_memadr", T_MEMADR,   OPC_SW, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("sw_wait",   T_MEMWRITE, OPC_SW, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus("sw_done",   T_MEMWRITE, OPC_SW, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("j_fetch",   T_FETCH,    OPC_J,  1'b1, 1'b0, 1'b0, 4);
    applyStimulus("j_decode",  T_DECODE,   OPC_J,  1'b0, 1'b0, 1'b0, 4);
    applyStimulus("j_jump",    T_JUMP,     OPC_J,  1'b0, 1'b0, 1'b0, 4);
    applyStimulus("ad_fetch",  T_FETCH,    OPC_ADDI, 1'b1, 1'b0, 1'b0, 5);
    applyStimulus("ad_decode", T_DECODE,   OPC_ADDI, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus("ad_exec",   T_ADDIEXEC, OPC_ADDI, 1'b1, 1'b1, 1'b0, 5);
    applyStimulus("ad_wb",     T_ADDIWB,   OPC_ADDI, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus("final",     T_FETCH,    OPC_R,    1'b0, 1'b0, 1'b0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
